// File: rtl/snake_pkg.sv
// Shared Snake playfield constants, food spawner state encoding and grid coordinate type.
// The SCAN states exist only when SNAKE_FOOD_SCAN_EN is defined.
package snake_pkg;

    localparam int GRID_W    = 40;
    localparam int GRID_H    = 30;
    localparam int X_BITS    = 6;
    localparam int Y_BITS    = 5;
    localparam int CELLS     = GRID_W * GRID_H;
    localparam int SCAN_BITS = $clog2(CELLS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RND,
        QUERY,
        CHECK,
`ifdef SNAKE_FOOD_SCAN_EN
        SCAN_Q,
        SCAN_C,
`endif
        FIN
    } spawn_state_t;

    typedef struct packed {
        logic [X_BITS-1:0] x;
        logic [Y_BITS-1:0] y;
    } coord_t;

    // One extra bit on the compare so a grid exactly 2^BITS wide still works.
    function automatic logic in_grid(coord_t c);
        return ({1'b0, c.x} < (X_BITS+1)'(GRID_W)) && ({1'b0, c.y} < (Y_BITS+1)'(GRID_H));
    endfunction

endpackage

// File: rtl/food_coord_step.sv
// Raster-order successor of a grid cell: x+1, wrapping to the next row, last cell wraps to (0,0).
module food_coord_step
    import snake_pkg::*;
(
    input  logic [X_BITS-1:0] x,
    input  logic [Y_BITS-1:0] y,
    output logic [X_BITS-1:0] x_next,
    output logic [Y_BITS-1:0] y_next
);

    always_comb begin
        x_next = x + 1'b1;
        y_next = y;
        if (x == X_BITS'(GRID_W - 1)) begin
            x_next = '0;
            y_next = (y == Y_BITS'(GRID_H - 1)) ? '0 : y + 1'b1;
        end
    end

endmodule

// File: rtl/food_spawner.sv
// Picks a free food cell from random candidates, checking each against the board occupancy RAM.
// Optional SNAKE_FOOD_SCAN_EN: linear board scan once the try limit is reached.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for spawn_req
//   WAIT_RND | waiting for a random word, rejects out-of-range candidates
//   QUERY    | occupancy read strobe for the candidate
//   CHECK    | occ_hit sampled; free -> FIN, occupied -> retry
//   SCAN_Q   | scan read strobe for the current scan cell
//   SCAN_C   | scan occ_hit sampled; occupied -> step to next cell
//   FIN      | one-cycle done pulse, result already latched
module food_spawner
    import snake_pkg::*;
#(
    parameter int MAX_TRIES = 64,
    parameter int TRY_BITS  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spawn_req,
    input  logic [14:0]       rnd,
    input  logic              rnd_valid,
    output logic              occ_rd,
    output logic [X_BITS-1:0] occ_x,
    output logic [Y_BITS-1:0] occ_y,
    input  logic              occ_hit,
    output logic [X_BITS-1:0] food_x,
    output logic [Y_BITS-1:0] food_y,
    output logic              food_valid,
    output logic              done,
    output logic              fail,
    output logic              busy
);

    spawn_state_t state, state_n;
    coord_t cur, cur_n, food, food_n, nxt, rnd_c;
    logic [TRY_BITS-1:0] tries, tries_n, tries_inc;
    logic food_valid_n, fail_n, at_limit;

    logic unused_rnd;
    assign unused_rnd = ^rnd[14:X_BITS+Y_BITS];

    food_coord_step u_step (
        .x      (cur.x),
        .y      (cur.y),
        .x_next (nxt.x),
        .y_next (nxt.y)
    );

`ifdef SNAKE_FOOD_SCAN_EN
    logic [SCAN_BITS-1:0] scan_cnt, scan_cnt_n;

    always_ff @(posedge clk) begin
        if (rst) scan_cnt <= '0;
        else     scan_cnt <= scan_cnt_n;
    end
`else
    logic unused_step;
    assign unused_step = ^nxt;
`endif

    assign rnd_c     = '{x: rnd[X_BITS-1:0], y: rnd[X_BITS+Y_BITS-1:X_BITS]};
    assign tries_inc = tries + 1'b1;
    assign at_limit  = (tries_inc == TRY_BITS'(MAX_TRIES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cur        <= '0;
            tries      <= '0;
            food       <= '0;
            food_valid <= 1'b0;
            fail       <= 1'b0;
        end else begin
            state      <= state_n;
            cur        <= cur_n;
            tries      <= tries_n;
            food       <= food_n;
            food_valid <= food_valid_n;
            fail       <= fail_n;
        end
    end

    always_comb begin
        state_n      = state;
        cur_n        = cur;
        tries_n      = tries;
        food_n       = food;
        food_valid_n = food_valid;
        fail_n       = fail;
`ifdef SNAKE_FOOD_SCAN_EN
        scan_cnt_n   = scan_cnt;
`endif
        unique case (state)
            IDLE: begin
                if (spawn_req) begin
                    state_n      = WAIT_RND;
                    food_valid_n = 1'b0;
                    fail_n       = 1'b0;
                    tries_n      = '0;
                end
            end
            WAIT_RND: begin
                if (rnd_valid) begin
                    cur_n = rnd_c;
                    if (in_grid(rnd_c)) begin
                        state_n = QUERY;
                    end else begin
                        tries_n = tries_inc;
                        if (at_limit) begin
`ifdef SNAKE_FOOD_SCAN_EN
                            cur_n      = '0;
                            scan_cnt_n = '0;
                            state_n    = SCAN_Q;
`else
                            fail_n  = 1'b1;
                            state_n = FIN;
`endif
                        end
                    end
                end
            end
            QUERY: state_n = CHECK;
            CHECK: begin
                if (!occ_hit) begin
                    food_n       = cur;
                    food_valid_n = 1'b1;
                    state_n      = FIN;
                end else begin
                    tries_n = tries_inc;
                    if (at_limit) begin
`ifdef SNAKE_FOOD_SCAN_EN
                        scan_cnt_n = '0;
                        state_n    = SCAN_Q;
`else
                        fail_n  = 1'b1;
                        state_n = FIN;
`endif
                    end else begin
                        state_n = WAIT_RND;
                    end
                end
            end
`ifdef SNAKE_FOOD_SCAN_EN
            SCAN_Q: state_n = SCAN_C;
            SCAN_C: begin
                if (!occ_hit) begin
                    food_n       = cur;
                    food_valid_n = 1'b1;
                    state_n      = FIN;
                end else if (scan_cnt == SCAN_BITS'(CELLS - 1)) begin
                    fail_n  = 1'b1;
                    state_n = FIN;
                end else begin
                    cur_n      = nxt;
                    scan_cnt_n = scan_cnt + 1'b1;
                    state_n    = SCAN_Q;
                end
            end
`endif
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

`ifdef SNAKE_FOOD_SCAN_EN
    assign occ_rd = (state == QUERY) || (state == SCAN_Q);
`else
    assign occ_rd = (state == QUERY);
`endif
    assign occ_x  = cur.x;
    assign occ_y  = cur.y;
    assign food_x = food.x;
    assign food_y = food.y;
    assign done   = (state == FIN);
    assign busy   = (state != IDLE);

endmodule
